// File: rtl/uart_pkg.sv
// Shared UART definitions: baud_sel encodings, clocks-per-bit table for a
// 50 MHz clock, and the transmit state enum. The receive path imports the
// same package so both directions decode baud_sel identically.
package uart_pkg;

  // baud_sel encodings
  localparam logic [2:0] BAUD_9600   = 3'b000;
  localparam logic [2:0] BAUD_19200  = 3'b001;
  localparam logic [2:0] BAUD_38400  = 3'b010;
  localparam logic [2:0] BAUD_57600  = 3'b011;
  localparam logic [2:0] BAUD_115200 = 3'b100;

  // Clocks per bit at 50 MHz
  localparam logic [15:0] DIV_9600    = 16'd5208;
  localparam logic [15:0] DIV_19200   = 16'd2604;
  localparam logic [15:0] DIV_38400   = 16'd1302;
  localparam logic [15:0] DIV_57600   = 16'd868;
  localparam logic [15:0] DIV_115200  = 16'd434;

  // Reserved encodings fall back to the slowest rate
  localparam logic [15:0] DIV_DEFAULT = DIV_9600;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Map a baud_sel code to its clocks-per-bit value.
  function automatic logic [15:0] baud_div(input logic [2:0] sel);
    case (sel)
      BAUD_9600:   return DIV_9600;
      BAUD_19200:  return DIV_19200;
      BAUD_38400:  return DIV_38400;
      BAUD_57600:  return DIV_57600;
      BAUD_115200: return DIV_115200;
      default:     return DIV_DEFAULT;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: a 16-bit down-counter loaded with div-1 on restart and
// reloaded automatically at every bit end, so each period is exactly div
// clocks with no accumulated error. bit_end is high on the last clock of a
// bit period while the timer is running.
module uart_baud_tick (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  input  logic        run,
  input  logic [15:0] div,
  output logic        bit_end
);

  logic [15:0] cnt_r;

  assign bit_end = run && (cnt_r == 16'd0);

  // Down-counter: load on restart, reload on bit end, otherwise count down.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 16'd0;
    end else if (restart) begin
      cnt_r <= div - 16'd1;
    end else if (run) begin
      if (cnt_r == 16'd0) begin
        cnt_r <= div - 16'd1;
      end else begin
        cnt_r <= cnt_r - 16'd1;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/uart_tx_baud.sv
// UART transmitter with integrated bit-rate divider. One frame per accepted
// byte: start bit, DATA_BITS data bits LSB first, optional parity bit,
// STOP_BITS stop bits. tx and busy are registered; tx_ready is the only
// combinational output.
// Optional feature macro: UART_TX_PARITY_EN adds the parity_odd input and a
// parity bit after the data bits.
module uart_tx_baud
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int DIV_OVERRIDE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           baud_sel,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
`ifdef UART_TX_PARITY_EN
  input  logic                 parity_odd,
`endif
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  tx_state_e            state_r, state_nx;
  logic [DATA_BITS-1:0] shift_r, shift_nx;
  logic [3:0]           bit_cnt_r, bit_cnt_nx;
  logic [15:0]          div_r, div_nx;
  logic [15:0]          sel_div_s;
  logic [15:0]          tick_div_s;
  logic                 tx_r, tx_nx;
  logic                 busy_r, busy_nx;
  logic                 accept_s;
  logic                 run_s;
  logic                 bit_end_s;
`ifdef UART_TX_PARITY_EN
  logic                 par_r, par_nx;

  // Frame parity: XOR of the data bits, inverted for odd parity.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d,
                                       input logic odd);
    return (^d) ^ odd;
  endfunction
`endif

  assign tx_ready   = (state_r == ST_IDLE) && !rst;
  assign accept_s   = tx_valid && tx_ready;
  assign run_s      = (state_r != ST_IDLE);
  // The timer must start with the divisor being latched, not the stale one.
  assign tick_div_s = accept_s ? sel_div_s : div_r;
  assign tx         = tx_r;
  assign busy       = busy_r;

  // Divisor for the current baud_sel, or the fixed override when set.
  always_comb begin
    sel_div_s = DIV_DEFAULT;
    if (DIV_OVERRIDE != 0) begin
      sel_div_s = 16'(DIV_OVERRIDE);
    end else begin
      sel_div_s = baud_div(baud_sel);
    end
  end

  uart_baud_tick u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (accept_s),
    .run     (run_s),
    .div     (tick_div_s),
    .bit_end (bit_end_s)
  );

  // Next-state, shift register, bit counter and registered output values.
  always_comb begin
    state_nx   = state_r;
    shift_nx   = shift_r;
    bit_cnt_nx = bit_cnt_r;
    div_nx     = div_r;
`ifdef UART_TX_PARITY_EN
    par_nx     = par_r;
`endif
    tx_nx      = 1'b1;
    busy_nx    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nx   = ST_START;
          shift_nx   = tx_data;
          bit_cnt_nx = 4'd0;
          div_nx     = sel_div_s;
`ifdef UART_TX_PARITY_EN
          par_nx     = calc_parity(tx_data, parity_odd);
`endif
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_nx = ST_DATA;
        end else begin
          state_nx = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          shift_nx = shift_r >> 1;
          if (bit_cnt_r == LAST_DATA) begin
            bit_cnt_nx = 4'd0;
`ifdef UART_TX_PARITY_EN
            state_nx   = ST_PARITY;
`else
            state_nx   = ST_STOP;
`endif
          end else begin
            bit_cnt_nx = bit_cnt_r + 4'd1;
          end
        end else begin
          state_nx = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          state_nx = ST_STOP;
        end else begin
          state_nx = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          if (bit_cnt_r == LAST_STOP) begin
            bit_cnt_nx = 4'd0;
            state_nx   = ST_IDLE;
          end else begin
            bit_cnt_nx = bit_cnt_r + 4'd1;
          end
        end else begin
          state_nx = ST_STOP;
        end
      end
      default: begin
        state_nx   = ST_IDLE;
        bit_cnt_nx = 4'd0;
      end
    endcase

    // Line level for the state being entered, so tx is a pure register.
    case (state_nx)
      ST_IDLE:   tx_nx = 1'b1;
      ST_START:  tx_nx = 1'b0;
      ST_DATA:   tx_nx = shift_nx[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_nx = par_nx;
`else
      ST_PARITY: tx_nx = 1'b1;
`endif
      ST_STOP:   tx_nx = 1'b1;
      default:   tx_nx = 1'b1;
    endcase

    busy_nx = (state_nx != ST_IDLE);
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      shift_r   <= '0;
      bit_cnt_r <= 4'd0;
      div_r     <= 16'd0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_r     <= 1'b0;
`endif
    end else begin
      state_r   <= state_nx;
      shift_r   <= shift_nx;
      bit_cnt_r <= bit_cnt_nx;
      div_r     <= div_nx;
      tx_r      <= tx_nx;
      busy_r    <= busy_nx;
`ifdef UART_TX_PARITY_EN
      par_r     <= par_nx;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_baud.sv
// Self-checking bench for uart_tx_baud. A fast instance (DIV_OVERRIDE=4) is
// checked cycle by cycle against a frame model computed from bit positions;
// a table instance (DIV_OVERRIDE=0) has its start-bit length measured for
// every baud_sel code from a vector table.
module tb_uart_tx_baud;

  localparam int DIV_F = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME = (1 + 8 + PAR + 1) * DIV_F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // fast instance
  logic       f_rst, f_valid, f_ready, f_tx, f_busy;
  logic [2:0] f_sel;
  logic [7:0] f_data;
  // table instance
  logic       t_rst, t_valid, t_ready, t_tx, t_busy;
  logic [2:0] t_sel;
  logic [7:0] t_data;
`ifdef UART_TX_PARITY_EN
  logic       f_odd, t_odd;
`endif

  int total_cnt = 0;
  int pass_cnt  = 0;

  uart_tx_baud #(.DATA_BITS(8), .STOP_BITS(1), .DIV_OVERRIDE(DIV_F)) dut_fast (
    .clk(clk), .rst(f_rst), .baud_sel(f_sel), .tx_data(f_data), .tx_valid(f_valid),
`ifdef UART_TX_PARITY_EN
    .parity_odd(f_odd),
`endif
    .tx_ready(f_ready), .tx(f_tx), .busy(f_busy)
  );

  uart_tx_baud #(.DATA_BITS(8), .STOP_BITS(1), .DIV_OVERRIDE(0)) dut_tab (
    .clk(clk), .rst(t_rst), .baud_sel(t_sel), .tx_data(t_data), .tx_valid(t_valid),
`ifdef UART_TX_PARITY_EN
    .parity_odd(t_odd),
`endif
    .tx_ready(t_ready), .tx(t_tx), .busy(t_busy)
  );

  task automatic check(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference: line level k clocks after the start bit begins.
  function automatic logic exp_tx(input logic [7:0] d, input logic odd, input int k);
    int idx;
    idx = k / DIV_F;
    if (idx == 0) return 1'b0;
    else if (idx <= 8) return d[idx-1];
    else if (PAR == 1 && idx == 9) return logic'(($countones(d) % 2) != 0) ^ odd;
    else return 1'b1;
  endfunction

  // Send one byte on the fast instance and check the whole frame.
  task automatic send_frame(input logic [7:0] d, input logic odd, input logic [2:0] sel,
                            input bit scramble, input bit keep_valid,
                            input logic [7:0] next_d, output int waited);
    f_data  = d;
    f_sel   = sel;
    f_valid = 1'b1;
`ifdef UART_TX_PARITY_EN
    f_odd   = odd;
`endif
    waited = 0;
    #1;
    while (!f_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", int'(f_ready), 1);
    if (!f_ready) begin
      f_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (keep_valid) begin
      f_data = next_d;
    end else begin
      f_valid = 1'b0;
      if (scramble) f_data = ~d;
    end
    if (scramble) begin
      f_sel = 3'($urandom_range(0, 7));
`ifdef UART_TX_PARITY_EN
      f_odd = ~odd;
`endif
    end
    for (int k = 0; k < FRAME; k++) begin
      check($sformatf("tx_bit[%0d] d=%02h", k, d), int'(f_tx), int'(exp_tx(d, odd, k)));
      check("busy_in_frame", int'(f_busy), 1);
      check("ready_in_frame", int'(f_ready), 0);
      @(negedge clk);
    end
    check("tx_after_frame", int'(f_tx), 1);
    check("busy_after_frame", int'(f_busy), 0);
    check("ready_after_frame", int'(f_ready), 1);
  endtask

  typedef struct {
    logic [2:0] sel;
    logic [2:0] alt_sel;
    int         div;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int w, w2, n;
    logic [7:0] rd;
    logic       ro;

    tbl[0] = '{3'b000, 3'b100, 5208};
    tbl[1] = '{3'b001, 3'b000, 2604};
    tbl[2] = '{3'b010, 3'b100, 1302};
    tbl[3] = '{3'b011, 3'b000, 868};
    tbl[4] = '{3'b100, 3'b111, 434};
    tbl[5] = '{3'b101, 3'b100, 5208};
    tbl[6] = '{3'b110, 3'b100, 5208};
    tbl[7] = '{3'b111, 3'b100, 5208};

    f_rst = 1'b1; f_valid = 1'b0; f_sel = 3'b000; f_data = 8'h00;
    t_rst = 1'b1; t_valid = 1'b0; t_sel = 3'b000; t_data = 8'h00;
`ifdef UART_TX_PARITY_EN
    f_odd = 1'b0; t_odd = 1'b0;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", int'(f_tx), 1);
    check("rst_busy", int'(f_busy), 0);
    check("rst_ready", int'(f_ready), 0);
    check("rst_tab_tx", int'(t_tx), 1);
    check("rst_tab_ready", int'(t_ready), 0);
    f_rst = 1'b0; t_rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", int'(f_ready), 1);
    check("tab_ready_after_rst", int'(t_ready), 1);
    check("idle_tx", int'(f_tx), 1);

    // Basic frame 0xA5
    send_frame(8'hA5, 1'b0, 3'b000, 1'b0, 1'b0, 8'h00, w);

    // Back-to-back 0x11 then 0x22 with tx_valid held
    send_frame(8'h11, 1'b0, 3'b001, 1'b0, 1'b1, 8'h22, w);
    send_frame(8'h22, 1'b0, 3'b001, 1'b0, 1'b0, 8'h00, w2);
    check("b2b_no_extra_wait", w2, 0);

    // Mid-frame data/baud change must not disturb the frame
    send_frame(8'h3C, 1'b1, 3'b100, 1'b1, 1'b0, 8'h00, w);

`ifdef UART_TX_PARITY_EN
    send_frame(8'h07, 1'b0, 3'b000, 1'b0, 1'b0, 8'h00, w);
    send_frame(8'h07, 1'b1, 3'b000, 1'b0, 1'b0, 8'h00, w);
`endif

    // Reset during data bit 3
    f_data = 8'hA5; f_valid = 1'b1;
    #1;
    n = 0;
    while (!f_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    f_valid = 1'b0;
    repeat (DIV_F * 4 + 1) @(negedge clk);
    check("pre_rst_bit3", int'(f_tx), int'(exp_tx(8'hA5, 1'b0, DIV_F * 4 + 1)));
    check("pre_rst_busy", int'(f_busy), 1);
    f_rst = 1'b1;
    #1;
    check("ready_during_rst", int'(f_ready), 0);
    @(negedge clk);
    check("rst_mid_tx", int'(f_tx), 1);
    check("rst_mid_busy", int'(f_busy), 0);
    check("rst_mid_ready", int'(f_ready), 0);
    f_rst = 1'b0;
    @(negedge clk);
    check("ready_after_mid_rst", int'(f_ready), 1);
    send_frame(8'h5A, 1'b1, 3'b010, 1'b0, 1'b0, 8'h00, w);

    // Randomized frames against the model
    for (int i = 0; i < 24; i++) begin
      rd = 8'($urandom);
      ro = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_frame(rd, ro, 3'($urandom_range(0, 7)), bit'($urandom_range(0, 1)), 1'b0, 8'h00, w);
    end

    // Table instance: start-bit length per baud_sel, baud_sel changed after accept
    for (int i = 0; i < 8; i++) begin
      t_data = 8'h01; t_sel = tbl[i].sel; t_valid = 1'b1;
      #1;
      n = 0;
      while (!t_ready && n < 100) begin @(negedge clk); n++; end
      check("tab_accept_ready", int'(t_ready), 1);
      @(negedge clk);
      t_valid = 1'b0; t_sel = tbl[i].alt_sel; t_data = 8'h00;
      n = 0;
      while (t_tx == 1'b0 && n < 6000) begin @(negedge clk); n++; end
      check($sformatf("start_len sel=%0d", tbl[i].sel), n, tbl[i].div);
      check("tab_bit0_high", int'(t_tx), 1);
      check("tab_busy", int'(t_busy), 1);
      t_rst = 1'b1;
      @(negedge clk);
      check("tab_rst_tx", int'(t_tx), 1);
      check("tab_rst_busy", int'(t_busy), 0);
      t_rst = 1'b0;
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
